// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
package booth_pkg;
  localparam int N     = 4;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/subtract of m, then arithmetic
// shift right of {acc,q,q_m1} by one bit.
module booth_step #(
  parameter int N = 4
) (
  input  logic [N:0]   acc,
  input  logic [N-1:0] q,
  input  logic         q_m1,
  input  logic [N:0]   m,
  output logic [N:0]   acc_n,
  output logic [N-1:0] q_n,
  output logic         q_m1_n
);
  logic [N:0] sum;

  always_comb begin
    sum = acc;
    case ({q[0], q_m1})
      2'b10:   sum = acc - m;
      2'b01:   sum = acc + m;
      default: sum = acc;
    endcase
  end

  // acc MSB is replicated; the bit leaving acc enters the top of q.
  assign acc_n  = {sum[N], sum[N:1]};
  assign q_n    = {sum[0], q[N-1:1]};
  assign q_m1_n = q[0];
endmodule

// File: rtl/booth.sv
// Sequential signed Booth multiplier: loads a/b on the first edge after
// reset, runs N steps, then holds the 2N-bit product on c until next reset.
module booth
  import booth_pkg::*;
#(
  parameter int N = booth_pkg::N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic [2*N-1:0]   c
);
  localparam int CW = $clog2(N + 1);

  state_t        state, state_nx;
  logic [CW-1:0] count;
  logic [N:0]    acc, m;
  logic [N-1:0]  q;
  logic          q_m1;

  logic [N:0]    acc_n;
  logic [N-1:0]  q_n;
  logic          q_m1_n;

  booth_step #(.N(N)) u_step (
    .acc    (acc),
    .q      (q),
    .q_m1   (q_m1),
    .m      (m),
    .acc_n  (acc_n),
    .q_n    (q_n),
    .q_m1_n (q_m1_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    state_nx = RUN;
      RUN:     if (count == CW'(1)) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      acc   <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      m     <= '0;
      c     <= '0;
    end else begin
      case (state)
        LOAD: begin
          m     <= {a[N-1], a};
          q     <= b;
          acc   <= '0;
          q_m1  <= 1'b0;
          count <= CW'(N);
        end
        RUN: begin
          acc   <= acc_n;
          q     <= q_n;
          q_m1  <= q_m1_n;
          count <= count - CW'(1);
          // Product only appears once the last step lands.
          if (count == CW'(1)) c <= {acc_n[N-1:0], q_n};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_booth.sv
// Self-checking bench for booth: spec vectors, random and exhaustive
// products against plain signed multiplication, reset abort and hold cases.
module tb_booth;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0, b = '0;
  logic [7:0] c;

  int n_checks = 0;
  int n_fail   = 0;

  booth dut (.clk(clk), .rst(rst), .a(a), .b(b), .c(c));

  always #20 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[7:0];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: c=%h expected %h", name, act, exp);
    end
  endtask

  // Pulse rst for one period with operands set, then release on a falling edge.
  task automatic start(input logic [3:0] ai, input logic [3:0] bi);
    @(negedge clk);
    a   = ai;
    b   = bi;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Walk the 5 edges after release; optionally verify c stays 0 until the last.
  task automatic run_case(input string name, input logic [3:0] ai, input logic [3:0] bi,
                          input logic [7:0] exp, input bit chk_early);
    start(ai, bi);
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      if (e < 5 && chk_early) check({name, "_early"}, c, 8'h00);
    end
    check(name, c, exp);
  endtask

  initial begin
    vecs[0] = '{4'd2, 4'd7, 8'h0E};
    vecs[1] = '{4'd3, 4'd5, 8'h0F};
    vecs[2] = '{4'd6, 4'd4, 8'h18};
    vecs[3] = '{4'h8, 4'h8, 8'h40};
    vecs[4] = '{4'hD, 4'd5, 8'hF1};
    vecs[5] = '{4'd7, 4'h8, 8'hC8};

    #5;
    check("reset_c", c, 8'h00);
    @(posedge clk);
    #1;
    check("reset_held", c, 8'h00);

    foreach (vecs[i])
      run_case($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);

    // Hold: operand changes after done must not disturb c.
    run_case("hold_base", 4'd7, 4'h8, 8'hC8, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = 4'($urandom);
      b = 4'($urandom);
      @(posedge clk);
      #1;
      check("hold", c, 8'hC8);
    end

    // Async clear of a finished product, before any edge.
    @(negedge clk);
    #5 rst = 1'b1;
    #2 check("async_clr_done", c, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Abort mid-run, then restart with new operands.
    start(4'd5, 4'd3);
    @(posedge clk);
    @(posedge clk);
    #5 rst = 1'b1;
    #2 check("abort_c", c, 8'h00);
    @(posedge clk);
    #1 check("abort_held", c, 8'h00);
    @(negedge clk);
    a   = 4'd1;
    b   = 4'hF;
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      if (e < 5) check("restart_early", c, 8'h00);
    end
    check("restart", c, 8'hFF);

    // Zero multiplicand with arbitrary multiplier.
    for (int i = 0; i < 3; i++) begin
      logic [3:0] rb;
      rb = 4'($urandom);
      run_case("a_zero", 4'd0, rb, 8'h00, 1'b0);
    end

    for (int i = 0; i < 20; i++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom);
      rb = 4'($urandom);
      run_case($sformatf("rand_%0d_%0d", $signed(ra), $signed(rb)), ra, rb, ref_mul(ra, rb), 1'b1);
    end

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run_case($sformatf("sweep_%0d_%0d", i, j), 4'(i), 4'(j), ref_mul(4'(i), 4'(j)), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
